// File: rtl/ov7670_reg_sequencer.sv
// OV7670 power-up and register-table sequencer: walks a registered ROM and
// issues one SCCB write per entry, honouring delay/end markers and retrying NACKs.
module ov7670_reg_sequencer #(
  parameter int PWDN_CYCLES  = 1000,
  parameter int PWRUP_CYCLES = 100000,
  parameter int DELAY_UNIT   = 10000,
  parameter int ADDR_W       = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_data,
  input  logic              sccb_ack,
  input  logic              sccb_nack,
  output logic              pwdn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index
);

  localparam int DLY_W   = 8 + $clog2(DELAY_UNIT);
  localparam int PWR_W   = $clog2(PWDN_CYCLES + PWRUP_CYCLES + 1);
  localparam int CNT_W   = (DLY_W > PWR_W) ? DLY_W : PWR_W;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // The start cycle itself is the first cycle of the power-down pulse.
  localparam logic [CNT_W-1:0] PWDN_LOAD  = CNT_W'((PWDN_CYCLES >= 2) ? PWDN_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'((PWRUP_CYCLES >= 1) ? PWRUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DU_C       = CNT_W'(DELAY_UNIT);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_PWDN, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE,
    S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                req_q, req_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                pwdn_q, pwdn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   err_index_q, err_index_d;
  logic [CNT_W-1:0]    dly_cycles;

  assign dly_cycles = CNT_W'(rom_data[7:0]) * DU_C;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    retry_d     = retry_q;
    req_d       = req_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pwdn_d      = pwdn_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          busy_d      = 1'b1;
          pwdn_d      = 1'b1;
          cnt_d       = PWDN_LOAD;
          state_d     = S_PWDN;
        end
      end
      S_PWDN: begin
        if (cnt_q == '0) begin
          pwdn_d  = 1'b0;
          cnt_d   = PWRUP_LOAD;
          state_d = S_PWRUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PWRUP: begin
        if (cnt_q == '0) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFEFF) begin
          state_d = S_DONE;
        end else if (rom_data[15:8] == 8'hFF) begin
          // A zero-length delay skips the DELAY state entirely.
          if (rom_data[7:0] == 8'h00) begin
            state_d = S_NEXT;
          end else begin
            cnt_d   = dly_cycles - 1'b1;
            state_d = S_DELAY;
          end
        end else begin
          addr_d  = rom_data[15:8];
          data_d  = rom_data[7:0];
          retry_d = '0;
          req_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sccb_ack) begin
          req_d   = 1'b0;
          state_d = S_NEXT;
        end else if (sccb_nack) begin
          req_d = 1'b0;
          if (retry_q == RETRY_MAX) begin
            state_d = S_ERROR;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        req_d   = 1'b1;
        state_d = S_ISSUE;
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_NEXT: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        error_d     = 1'b1;
        busy_d      = 1'b0;
        err_index_d = rom_addr_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      retry_q     <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pwdn_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      retry_q     <= retry_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pwdn_q      <= pwdn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign sccb_req  = req_q;
  assign sccb_addr = addr_q;
  assign sccb_data = data_q;
  assign pwdn      = pwdn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;

endmodule
